// File: rtl/ram_load_pkg.sv
// Shared types and default geometry for the RAM program-load sequencer.
package ram_load_pkg;

  localparam int WIDTH_DEF  = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CPU,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/ram_load_ctrl_if.sv
// Load command, word stream, CPU arbitration and MAR/RAM drive signals.
interface ram_load_ctrl_if #(
  parameter int WIDTH  = 4,
  parameter int DATA_W = 8
);

  logic              start;
  logic [WIDTH-1:0]  start_addr;
  logic [WIDTH-1:0]  len;
  logic              abort;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              cpu_req;
  logic              cpu_gnt;
  logic              prog;
  logic [WIDTH-1:0]  addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic              busy;
  logic              done;

  modport master (
    output start, start_addr, len, abort, in_valid, in_data, cpu_req,
    input  in_ready, cpu_gnt, prog, addr, ram_we, ram_wdata, busy, done
  );

  modport slave (
    input  start, start_addr, len, abort, in_valid, in_data, cpu_req,
    output in_ready, cpu_gnt, prog, addr, ram_we, ram_wdata, busy, done
  );

endinterface

// File: rtl/ram_load_cnt.sv
// Write-address / words-remaining counter pair: parallel load, wrapping
// address increment with remaining decrement, and a zero flag.
module ram_load_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_addr,
  input  logic [WIDTH-1:0] load_len,
  input  logic             step,
  output logic [WIDTH-1:0] cur_addr,
  output logic [WIDTH-1:0] remaining,
  output logic             zero
);

  logic [WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cur_addr_q  <= '0;
      remaining_q <= '0;
    end else begin
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
    end
  end

  // Address rolls over naturally at 2**WIDTH.
  always_comb begin
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    if (load) begin
      cur_addr_d  = load_addr;
      remaining_d = load_len;
    end else if (step) begin
      cur_addr_d  = cur_addr_q + WIDTH'(1);
      remaining_d = remaining_q - WIDTH'(1);
    end
  end

  assign cur_addr  = cur_addr_q;
  assign remaining = remaining_q;
  assign zero      = (remaining_q == '0);

endmodule

// File: rtl/ram_load_ctrl.sv
// Program-load sequencer writing a valid/ready word stream into the 16x8 RAM,
// arbitrating the MAR/RAM path between the loader and the CPU.
module ram_load_ctrl
  import ram_load_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic            clk,
  input  logic            clr_n,
  ram_load_ctrl_if.slave  bus
);

  state_e            state_q, state_d;
  logic              pending_q, pending_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              cnt_load;
  logic              cnt_step;
  logic [WIDTH-1:0]  cur_addr;
  logic [WIDTH-1:0]  remaining;
  logic              cnt_zero;

  ram_load_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk       (clk),
    .clr_n     (clr_n),
    .load      (cnt_load),
    .load_addr (bus.start_addr),
    .load_len  (bus.len),
    .step      (cnt_step),
    .cur_addr  (cur_addr),
    .remaining (remaining),
    .zero      (cnt_zero)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    wdata_d   = wdata_q;
    cnt_load  = 1'b0;
    cnt_step  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_WAIT;
          cnt_load = 1'b1;
        end else if (bus.cpu_req) begin
          state_d = ST_CPU;
        end
      end
      ST_CPU: begin
        // Only the first start while the CPU holds the path is remembered.
        if (bus.start && !pending_q) begin
          pending_d = 1'b1;
          cnt_load  = 1'b1;
        end
        if (!bus.cpu_req) begin
          if (pending_d) begin
            state_d   = ST_WAIT;
            pending_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.in_valid) begin
          wdata_d = bus.in_data;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // The strobe for this cycle is already out; abort only cancels what follows.
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          state_d = ST_DONE;
        end else begin
          cnt_step = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == ST_WAIT);
    bus.cpu_gnt   = (state_q == ST_CPU);
    bus.prog      = (state_q == ST_WAIT) || (state_q == ST_WRITE);
    bus.ram_we    = (state_q == ST_WRITE);
    bus.done      = (state_q == ST_DONE);
    bus.busy      = (state_q == ST_WAIT) || (state_q == ST_WRITE) ||
                    (state_q == ST_DONE) || pending_q;
    bus.addr      = cur_addr;
    bus.ram_wdata = wdata_q;
  end

endmodule

// File: tb/tb_ram_load_ctrl.sv
// Directed self-checking bench for ram_load_ctrl with a shadow RAM and
// write/done monitors.
module tb_ram_load_ctrl;
  import ram_load_pkg::*;

  logic clk;
  logic clr_n;
  int   assertCount;
  int   failCount;
  int   weCount;
  int   doneCount;
  int   consecWe;
  logic prevWe;
  logic [DATA_W_DEF-1:0] mem [2**WIDTH_DEF];
  logic [WIDTH_DEF-1:0]  addrLog [$];
  int   w0;
  int   d0;

  ram_load_ctrl_if #(.WIDTH(WIDTH_DEF), .DATA_W(DATA_W_DEF)) bus ();

  ram_load_ctrl #(.WIDTH(WIDTH_DEF), .DATA_W(DATA_W_DEF)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shadow RAM and strobe monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.ram_we) begin
      mem[bus.addr] = bus.ram_wdata;
      addrLog.push_back(bus.addr);
      weCount = weCount + 1;
      if (prevWe) consecWe = consecWe + 1;
    end
    if (bus.done) doneCount = doneCount + 1;
    prevWe = bus.ram_we;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount = assertCount + 1;
    if (obs !== exp) begin
      failCount = failCount + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [WIDTH_DEF-1:0] sa,
                               input logic [WIDTH_DEF-1:0] ln, input logic ab,
                               input logic iv, input logic [DATA_W_DEF-1:0] d,
                               input logic cr);
    bus.start      = s;
    bus.start_addr = sa;
    bus.len        = ln;
    bus.abort      = ab;
    bus.in_valid   = iv;
    bus.in_data    = d;
    bus.cpu_req    = cr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    assertCount = 0; failCount = 0; weCount = 0; doneCount = 0;
    consecWe = 0; prevWe = 1'b0;
    for (int i = 0; i < 2**WIDTH_DEF; i++) mem[i] = '0;
    clr_n = 1'b0;
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0);
    tick(); tick();
    checkOutput("rst_in_ready", bus.in_ready, 0);
    checkOutput("rst_cpu_gnt", bus.cpu_gnt, 0);
    checkOutput("rst_prog", bus.prog, 0);
    checkOutput("rst_addr", bus.addr, 0);
    checkOutput("rst_ram_we", bus.ram_we, 0);
    checkOutput("rst_wdata", bus.ram_wdata, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    clr_n = 1'b1;
    tick();

    // Reset asserted in the middle of a WRITE cycle.
    applyStimulus(1'b1, 4'd3, 4'd3, 1'b0, 1'b1, 8'h77, 1'b0);
    tick();
    bus.start = 1'b0;
    tick();
    checkOutput("mid_we_before_rst", bus.ram_we, 1);
    clr_n = 1'b0;
    #1;
    checkOutput("mid_rst_we", bus.ram_we, 0);
    checkOutput("mid_rst_prog", bus.prog, 0);
    checkOutput("mid_rst_busy", bus.busy, 0);
    checkOutput("mid_rst_addr", bus.addr, 0);
    checkOutput("mid_rst_wdata", bus.ram_wdata, 0);
    checkOutput("mid_rst_in_ready", bus.in_ready, 0);
    tick();
    clr_n = 1'b1;
    w0 = weCount;
    repeat (6) tick();
    checkOutput("post_rst_no_we", weCount, w0);
    bus.in_valid = 1'b0;
    tick();

    // Basic load of four words from address 0 with in_valid held.
    w0 = weCount; d0 = doneCount;
    applyStimulus(1'b1, 4'd0, 4'd3, 1'b0, 1'b1, 8'hA1, 1'b0);
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("basic_ready%0d", i), bus.in_ready, 1);
      checkOutput($sformatf("basic_idle_we%0d", i), bus.ram_we, 0);
      tick();
      checkOutput($sformatf("basic_we%0d", i), bus.ram_we, 1);
      checkOutput($sformatf("basic_notready%0d", i), bus.in_ready, 0);
      checkOutput($sformatf("basic_addr%0d", i), bus.addr, i);
      checkOutput($sformatf("basic_data%0d", i), bus.ram_wdata, 8'hA1 + i);
      bus.in_data = 8'hA2 + 8'(i);
      tick();
    end
    checkOutput("basic_done", bus.done, 1);
    checkOutput("basic_done_we", bus.ram_we, 0);
    tick();
    checkOutput("basic_done_clear", bus.done, 0);
    checkOutput("basic_idle_busy", bus.busy, 0);
    checkOutput("basic_we_count", weCount - w0, 4);
    checkOutput("basic_mem3", mem[3], 8'hA4);
    bus.in_valid = 1'b0;

    // Wrap-around load from address 14.
    addrLog.delete();
    w0 = weCount; d0 = doneCount;
    applyStimulus(1'b1, 4'd14, 4'd3, 1'b0, 1'b1, 8'h5A, 1'b0);
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 30 && bus.busy; c++) tick();
    checkOutput("wrap_finished", bus.busy, 0);
    checkOutput("wrap_count", addrLog.size(), 4);
    if (addrLog.size() == 4) begin
      checkOutput("wrap_a0", addrLog[0], 14);
      checkOutput("wrap_a1", addrLog[1], 15);
      checkOutput("wrap_a2", addrLog[2], 0);
      checkOutput("wrap_a3", addrLog[3], 1);
    end
    checkOutput("wrap_done_once", doneCount - d0, 1);
    bus.in_valid = 1'b0;
    tick();

    // Simultaneous start and cpu_req in IDLE: loader wins.
    applyStimulus(1'b1, 4'd2, 4'd0, 1'b0, 1'b1, 8'h61, 1'b1);
    tick();
    bus.start = 1'b0;
    checkOutput("arb1_gnt_wait", bus.cpu_gnt, 0);
    checkOutput("arb1_ready", bus.in_ready, 1);
    tick();
    checkOutput("arb1_gnt_write", bus.cpu_gnt, 0);
    checkOutput("arb1_we", bus.ram_we, 1);
    tick();
    checkOutput("arb1_gnt_done", bus.cpu_gnt, 0);
    checkOutput("arb1_done", bus.done, 1);
    tick();
    checkOutput("arb1_gnt_idle", bus.cpu_gnt, 0);
    tick();
    checkOutput("arb1_gnt", bus.cpu_gnt, 1);
    checkOutput("arb1_prog", bus.prog, 0);

    // Start while the CPU owns the path; second start is ignored.
    applyStimulus(1'b1, 4'd5, 4'd0, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("arb2_busy", bus.busy, 1);
    checkOutput("arb2_gnt", bus.cpu_gnt, 1);
    checkOutput("arb2_not_ready", bus.in_ready, 0);
    applyStimulus(1'b1, 4'd9, 4'd2, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("arb2_gnt_hold", bus.cpu_gnt, 1);
    applyStimulus(1'b0, 4'd9, 4'd2, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("arb2_gnt_drop", bus.cpu_gnt, 0);
    checkOutput("arb2_wait", bus.in_ready, 1);
    applyStimulus(1'b0, 4'd9, 4'd2, 1'b0, 1'b1, 8'h5C, 1'b0);
    tick();
    checkOutput("arb2_we", bus.ram_we, 1);
    checkOutput("arb2_addr", bus.addr, 5);
    checkOutput("arb2_data", bus.ram_wdata, 8'h5C);
    bus.in_valid = 1'b0;
    tick();
    checkOutput("arb2_done", bus.done, 1);
    tick();
    checkOutput("arb2_idle", bus.busy, 0);

    // Abort in WAIT after two of four writes.
    mem[2] = 8'hEE; mem[3] = 8'hEE;
    w0 = weCount; d0 = doneCount;
    applyStimulus(1'b1, 4'd0, 4'd3, 1'b0, 1'b1, 8'hB1, 1'b0);
    tick();
    bus.start = 1'b0;
    tick();
    bus.in_data = 8'hB2;
    tick(); tick();
    bus.in_data = 8'hB3;
    tick();
    checkOutput("abort_in_wait", bus.in_ready, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checkOutput("abort_idle_busy", bus.busy, 0);
    checkOutput("abort_idle_prog", bus.prog, 0);
    checkOutput("abort_no_we", bus.ram_we, 0);
    repeat (4) tick();
    checkOutput("abort_we_count", weCount - w0, 2);
    checkOutput("abort_no_done", doneCount - d0, 0);
    checkOutput("abort_mem1", mem[1], 8'hB2);
    checkOutput("abort_mem2", mem[2], 8'hEE);
    checkOutput("abort_mem3", mem[3], 8'hEE);
    bus.in_valid = 1'b0;
    tick();

    // Backpressure: no valid for five cycles in WAIT.
    w0 = weCount;
    applyStimulus(1'b1, 4'd7, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_ready%0d", i), bus.in_ready, 1);
      checkOutput($sformatf("bp_no_we%0d", i), bus.ram_we, 0);
      tick();
    end
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 8'h3D, 1'b0);
    tick();
    checkOutput("bp_we", bus.ram_we, 1);
    checkOutput("bp_addr", bus.addr, 7);
    checkOutput("bp_data", bus.ram_wdata, 8'h3D);
    bus.in_valid = 1'b0;
    tick();
    checkOutput("bp_done", bus.done, 1);
    tick();
    checkOutput("bp_we_count", weCount - w0, 1);

    checkOutput("no_back_to_back_we", consecWe, 0);
    checkOutput("total_done", doneCount, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
